// File: rtl/cdb_writeback_arbiter.sv
// Common data bus writeback arbiter.
// The ALU and MEM execution units each push completed results into their own
// small FIFO. Every cycle a round-robin arbiter picks one FIFO head. That head
// is registered onto the CDB together with a one-hot "set valid" strobe for
// the register status table.
module cdb_writeback_arbiter #(
  parameter int PHY_REG_NUM = 64,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  localparam int TAG_W      = $clog2(PHY_REG_NUM)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_wb_valid,
  output logic                   alu_wb_ready,
  input  logic [TAG_W-1:0]       alu_wb_tag,
  input  logic [DATA_W-1:0]      alu_wb_data,
  input  logic                   mem_wb_valid,
  output logic                   mem_wb_ready,
  input  logic [TAG_W-1:0]       mem_wb_tag,
  input  logic [DATA_W-1:0]      mem_wb_data,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [DATA_W-1:0]      cdb_data,
  output logic                   cdb_src,
  output logic [PHY_REG_NUM-1:0] status_set_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Physical register 0 is hardwired, so it is never marked ready.
  function automatic logic [PHY_REG_NUM-1:0] status_onehot(input logic [TAG_W-1:0] tag);
    status_onehot = '0;
    if (tag != '0) begin
      status_onehot[tag] = 1'b1;
    end
  endfunction

  // Count update shared by both FIFOs: a simultaneous push and pop cancel out.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] count,
                                                  input logic push,
                                                  input logic pop);
    next_count = count;
    case ({push, pop})
      2'b10:   next_count = count + CNT_W'(1);
      2'b01:   next_count = count - CNT_W'(1);
      default: next_count = count;
    endcase
  endfunction

  // Source FIFO storage (data path, not reset)
  logic [TAG_W-1:0]  alu_tag_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] alu_data_q [FIFO_DEPTH];
  logic [TAG_W-1:0]  mem_tag_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];

  // Source FIFO control
  logic [PTR_W-1:0] alu_wr_ptr, alu_rd_ptr;
  logic [PTR_W-1:0] mem_wr_ptr, mem_rd_ptr;
  logic [CNT_W-1:0] alu_count, mem_count;
  logic             alu_push, mem_push;
  logic             alu_pop, mem_pop;
  logic             alu_nonempty, mem_nonempty;

  // Round-robin pointer: 0 favours ALU, 1 favours MEM
  logic             rr_ptr;
  logic             contended;

  // Stage p0: arbitration result (combinational on FIFO heads)
  logic                   vld_p0;
  logic [TAG_W-1:0]       tag_p0;
  logic [DATA_W-1:0]      data_p0;
  logic                   src_p0;

  // Stage p1: registered broadcast
  logic                   vld_p1;
  logic [TAG_W-1:0]       tag_p1;
  logic [DATA_W-1:0]      data_p1;
  logic                   src_p1;
  logic [PHY_REG_NUM-1:0] status_p1;

  // Ready depends only on the registered count. A full FIFO therefore refuses a
  // push even in a cycle where it also pops.
  assign alu_wb_ready = (alu_count != CNT_W'(FIFO_DEPTH));
  assign mem_wb_ready = (mem_count != CNT_W'(FIFO_DEPTH));
  assign alu_push     = alu_wb_valid && alu_wb_ready;
  assign mem_push     = mem_wb_valid && mem_wb_ready;
  assign alu_nonempty = (alu_count != '0);
  assign mem_nonempty = (mem_count != '0);
  assign contended    = alu_nonempty && mem_nonempty;

  // Arbitration: a lone non-empty FIFO always wins; under contention rr_ptr decides.
  always_comb begin
    alu_pop = 1'b0;
    mem_pop = 1'b0;
    if (contended) begin
      alu_pop = (rr_ptr == 1'b0);
      mem_pop = (rr_ptr == 1'b1);
    end else begin
      alu_pop = alu_nonempty;
      mem_pop = mem_nonempty;
    end
  end

  // Head selection feeding the broadcast register.
  always_comb begin
    vld_p0  = alu_pop || mem_pop;
    src_p0  = mem_pop;
    tag_p0  = alu_tag_q[alu_rd_ptr];
    data_p0 = alu_data_q[alu_rd_ptr];
    if (mem_pop) begin
      tag_p0  = mem_tag_q[mem_rd_ptr];
      data_p0 = mem_data_q[mem_rd_ptr];
    end
  end

  // Write accepted results into the FIFO storage.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_tag_q[alu_wr_ptr]  <= alu_wb_tag;
      alu_data_q[alu_wr_ptr] <= alu_wb_data;
    end
    if (mem_push) begin
      mem_tag_q[mem_wr_ptr]  <= mem_wb_tag;
      mem_data_q[mem_wr_ptr] <= mem_wb_data;
    end
  end

  // ALU FIFO pointers and occupancy. Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_wr_ptr <= '0;
      alu_rd_ptr <= '0;
      alu_count  <= '0;
    end else begin
      if (alu_push) alu_wr_ptr <= alu_wr_ptr + PTR_W'(1);
      if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + PTR_W'(1);
      alu_count <= next_count(alu_count, alu_push, alu_pop);
    end
  end

  // MEM FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wr_ptr <= '0;
      mem_rd_ptr <= '0;
      mem_count  <= '0;
    end else begin
      if (mem_push) mem_wr_ptr <= mem_wr_ptr + PTR_W'(1);
      if (mem_pop)  mem_rd_ptr <= mem_rd_ptr + PTR_W'(1);
      mem_count <= next_count(mem_count, mem_push, mem_pop);
    end
  end

  // Hand priority to the loser only after a contended grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (contended) begin
      rr_ptr <= alu_pop;
    end
  end

  // Register the granted head onto the CDB. The valid and status strobes last one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      tag_p1    <= '0;
      data_p1   <= '0;
      src_p1    <= 1'b0;
      status_p1 <= '0;
    end else begin
      vld_p1    <= vld_p0;
      status_p1 <= vld_p0 ? status_onehot(tag_p0) : '0;
      if (vld_p0) begin
        tag_p1  <= tag_p0;
        data_p1 <= data_p0;
        src_p1  <= src_p0;
      end
    end
  end

  assign cdb_valid        = vld_p1;
  assign cdb_tag          = tag_p1;
  assign cdb_data         = data_p1;
  assign cdb_src          = src_p1;
  assign status_set_valid = status_p1;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench for cdb_writeback_arbiter.
// Expected broadcasts are queued in the order the arbiter must produce them.
// A negedge monitor pops the queue and compares each CDB beat against it.
module tb_cdb_writeback_arbiter;

  localparam int PHY = 64;
  localparam int DW  = 32;
  localparam int TW  = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           alu_wb_valid, mem_wb_valid;
  logic           alu_wb_ready, mem_wb_ready;
  logic [TW-1:0]  alu_wb_tag, mem_wb_tag;
  logic [DW-1:0]  alu_wb_data, mem_wb_data;
  logic           cdb_valid;
  logic [TW-1:0]  cdb_tag;
  logic [DW-1:0]  cdb_data;
  logic           cdb_src;
  logic [PHY-1:0] status_set_valid;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          src;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mem_full_seen = 1'b0;

  always #5 clk = ~clk;

  cdb_writeback_arbiter #(.PHY_REG_NUM(PHY), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_tag(alu_wb_tag), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
    .mem_wb_tag(mem_wb_tag), .mem_wb_data(mem_wb_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .status_set_valid(status_set_valid)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_status(input logic [TW-1:0] tag);
    logic [63:0] one;
    one = 64'd1;
    exp_status = (tag == '0) ? 64'd0 : (one << tag);
  endfunction

  function automatic exp_t mk(input int tag, input logic [DW-1:0] data, input logic src);
    mk.tag  = TW'(tag);
    mk.data = data;
    mk.src  = src;
  endfunction

  // Scoreboard monitor: every CDB beat must match the next expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (!mem_wb_ready) mem_full_seen = 1'b1;
      if (cdb_valid) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_bcast observed tag=%0d src=%0d expected no broadcast", cdb_tag, cdb_src);
        end
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_tag", 64'(cdb_tag), 64'(e.tag));
          check("sb_data", 64'(cdb_data), 64'(e.data));
          check("sb_src", 64'(cdb_src), 64'(e.src));
          check("sb_status", status_set_valid, exp_status(e.tag));
        end
      end else begin
        check("idle_status", status_set_valid, 64'd0);
      end
    end
  end

  // Offer results from both sources until the requested numbers have been accepted.
  task automatic dual_push(input int na, input int ta, input logic [DW-1:0] da,
                           input int nm, input int tm, input logic [DW-1:0] dm);
    int ai, mi;
    bit acc_a, acc_m;
    ai = 0;
    mi = 0;
    for (int cyc = 0; cyc < 60 && (ai < na || mi < nm); cyc++) begin
      alu_wb_valid = (ai < na);
      alu_wb_tag   = TW'(ta + ai);
      alu_wb_data  = da + DW'(ai);
      mem_wb_valid = (mi < nm);
      mem_wb_tag   = TW'(tm + mi);
      mem_wb_data  = dm + DW'(mi);
      acc_a = alu_wb_valid && alu_wb_ready;
      acc_m = mem_wb_valid && mem_wb_ready;
      @(posedge clk); #1;
      if (acc_a) ai++;
      if (acc_m) mi++;
    end
    alu_wb_valid = 1'b0;
    mem_wb_valid = 1'b0;
    check("alu_pushed", 64'(ai), 64'(na));
    check("mem_pushed", 64'(mi), 64'(nm));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    alu_wb_valid = 1'b0; alu_wb_tag = '0; alu_wb_data = '0;
    mem_wb_valid = 1'b0; mem_wb_tag = '0; mem_wb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_status", status_set_valid, 64'd0);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_valid", 64'(cdb_valid), 64'd0);
      check("idle_alu_ready", 64'(alu_wb_ready), 64'd1);
      check("idle_mem_ready", 64'(mem_wb_ready), 64'd1);
      check("idle_status_set", status_set_valid, 64'd0);
    end

    // Single ALU result: one cycle of latency, then a one-cycle strobe
    alu_wb_valid = 1'b1; alu_wb_tag = 6'd5; alu_wb_data = 32'hDEAD_BEEF;
    exp_q.push_back(mk(5, 32'hDEAD_BEEF, 1'b0));
    @(posedge clk); #1;
    alu_wb_valid = 1'b0;
    check("t2_not_yet", 64'(cdb_valid), 64'd0);
    @(posedge clk); #1;
    check("t2_valid", 64'(cdb_valid), 64'd1);
    check("t2_tag", 64'(cdb_tag), 64'd5);
    check("t2_src", 64'(cdb_src), 64'd0);
    check("t2_status", status_set_valid, 64'd1 << 5);
    @(posedge clk); #1;
    check("t2_valid_drop", 64'(cdb_valid), 64'd0);
    check("t2_status_drop", status_set_valid, 64'd0);

    // Tag 0 is broadcast but never marks a register ready
    alu_wb_valid = 1'b1; alu_wb_tag = 6'd0; alu_wb_data = 32'h0000_1234;
    exp_q.push_back(mk(0, 32'h0000_1234, 1'b0));
    @(posedge clk); #1;
    alu_wb_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_valid", 64'(cdb_valid), 64'd1);
    check("t5_tag", 64'(cdb_tag), 64'd0);
    check("t5_status", status_set_valid, 64'd0);
    drain("t5_drained");

    // Both sources stream 8 results; the CDB must alternate ALU, MEM from ALU1
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(1 + i, 32'hA000_0000 + DW'(i), 1'b0));
      exp_q.push_back(mk(9 + i, 32'hB000_0000 + DW'(i), 1'b1));
    end
    mem_full_seen = 1'b0;
    dual_push(8, 1, 32'hA000_0000, 8, 9, 32'hB000_0000);
    drain("t3_drained");
    check("t3_mem_full_seen", 64'(mem_full_seen), 64'd1);
    check("t3_mem_ready_back", 64'(mem_wb_ready), 64'd1);

    // The last contended grant went to ALU, so MEM is favoured first here
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(30 + i, 32'hD000_0000 + DW'(i), 1'b1));
      exp_q.push_back(mk(20 + i, 32'hC000_0000 + DW'(i), 1'b0));
    end
    exp_q.push_back(mk(34, 32'hD000_0004, 1'b1));
    dual_push(4, 20, 32'hC000_0000, 5, 30, 32'hD000_0000);
    drain("t4_drained");

    // Reset with results still queued. MEM is favoured again, so M50 goes out
    // first and A40 is on the bus when reset hits.
    exp_q.push_back(mk(50, 32'hF000_0000, 1'b1));
    dual_push(3, 40, 32'hE000_0000, 3, 50, 32'hF000_0000);
    check("t6_pre_valid", 64'(cdb_valid), 64'd1);
    check("t6_pre_tag", 64'(cdb_tag), 64'd40);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_valid", 64'(cdb_valid), 64'd0);
    check("t6_rst_tag", 64'(cdb_tag), 64'd0);
    check("t6_rst_data", 64'(cdb_data), 64'd0);
    check("t6_rst_src", 64'(cdb_src), 64'd0);
    check("t6_rst_status", status_set_valid, 64'd0);
    check("t6_rst_alu_ready", 64'(alu_wb_ready), 64'd1);
    check("t6_rst_mem_ready", 64'(mem_wb_ready), 64'd1);
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t6_no_bcast", 64'(cdb_valid), 64'd0);
    end
    alu_wb_valid = 1'b1; alu_wb_tag = 6'd7; alu_wb_data = 32'h0000_0077;
    exp_q.push_back(mk(7, 32'h0000_0077, 1'b0));
    @(posedge clk); #1;
    alu_wb_valid = 1'b0;
    drain("t6_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
